// File: rtl/mips_control_unit.sv
// Multicycle Moore control unit for the MIPS CPU: fetch, decode, execute, memory, write-back.
// Latency: 3 to 5 cycles per instruction (FETCH included); illegal encodings park in HALT until reset.
// No backpressure: advances one state per clock; outputs decode from the state and captured IR fields.
module mips_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    input  logic        V,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic [1:0]  pc_sel,
    output logic        im_cs,
    output logic        im_rd,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic        D_En,
    output logic [1:0]  D_sel,
    output logic        T_Sel,
    output logic        ext_sel,
    output logic        HILO_ld,
    output logic [2:0]  Y_Sel,
    output logic [4:0]  FS,
    output logic        halt
);

    // ALU function codes
    localparam logic [4:0] FS_ADD  = 5'h02;
    localparam logic [4:0] FS_ADDU = 5'h03;
    localparam logic [4:0] FS_SUB  = 5'h04;
    localparam logic [4:0] FS_SUBU = 5'h05;
    localparam logic [4:0] FS_SLT  = 5'h06;
    localparam logic [4:0] FS_SLTU = 5'h07;
    localparam logic [4:0] FS_AND  = 5'h08;
    localparam logic [4:0] FS_OR   = 5'h09;
    localparam logic [4:0] FS_XOR  = 5'h0A;
    localparam logic [4:0] FS_NOR  = 5'h0B;
    localparam logic [4:0] FS_SLL  = 5'h0C;
    localparam logic [4:0] FS_SRL  = 5'h0D;
    localparam logic [4:0] FS_SRA  = 5'h0E;
    localparam logic [4:0] FS_MULT = 5'h1E;
    localparam logic [4:0] FS_DIV  = 5'h1F;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE,
        S_EXEC_R, S_WB_R, S_EXEC_MD, S_WB_HL, S_JR,
        S_EXEC_I, S_WB_I,
        S_LW_ADDR, S_LW_MEM, S_LW_WB,
        S_SW_ADDR, S_SW_MEM,
        S_BR, S_J, S_JAL, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;

    // Flags N/C/V and the register/immediate fields of IR are datapath-only.
    logic unused_inputs;
    assign unused_inputs = ^{N, C, V, IR[25:6]};

    // Funct field to ALU code for the R-type ALU group; zero for non-ALU functs.
    function automatic logic [4:0] funct_fs(input logic [5:0] fn);
        case (fn)
            6'h20:   funct_fs = FS_ADD;
            6'h21:   funct_fs = FS_ADDU;
            6'h22:   funct_fs = FS_SUB;
            6'h23:   funct_fs = FS_SUBU;
            6'h24:   funct_fs = FS_AND;
            6'h25:   funct_fs = FS_OR;
            6'h26:   funct_fs = FS_XOR;
            6'h27:   funct_fs = FS_NOR;
            6'h2A:   funct_fs = FS_SLT;
            6'h2B:   funct_fs = FS_SLTU;
            6'h00:   funct_fs = FS_SLL;
            6'h02:   funct_fs = FS_SRL;
            6'h03:   funct_fs = FS_SRA;
            default: funct_fs = 5'h00;
        endcase
    endfunction

    function automatic logic is_r_alu(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03: is_r_alu = 1'b1;
            default:                           is_r_alu = 1'b0;
        endcase
    endfunction

    // State and captured opcode/funct registers; reset forces RESET asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            op_q    <= 6'h00;
            fn_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    // Next-state logic; opcode/funct are captured while DECODE dispatches on them.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = IR[31:26];
                fn_d = IR[5:0];
                case (IR[31:26])
                    6'h00: begin
                        case (IR[5:0])
                            6'h18, 6'h1A: state_d = S_EXEC_MD;
                            6'h10, 6'h12: state_d = S_WB_HL;
                            6'h08:        state_d = S_JR;
                            6'h0D:        state_d = S_HALT;
                            default:      state_d = is_r_alu(IR[5:0]) ? S_EXEC_R : S_HALT;
                        endcase
                    end
                    6'h08, 6'h0D: state_d = S_EXEC_I;
                    6'h23:        state_d = S_LW_ADDR;
                    6'h2B:        state_d = S_SW_ADDR;
                    6'h04, 6'h05: state_d = S_BR;
                    6'h02:        state_d = S_J;
                    6'h03:        state_d = S_JAL;
                    default:      state_d = S_HALT;
                endcase
            end
            S_EXEC_R:  state_d = S_WB_R;
            S_EXEC_I:  state_d = S_WB_I;
            S_LW_ADDR: state_d = S_LW_MEM;
            S_LW_MEM:  state_d = S_LW_WB;
            S_SW_ADDR: state_d = S_SW_MEM;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode; only BR looks at a live input (Z), which is valid once RS/RT are captured.
    always_comb begin
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        pc_sel  = 2'b00;
        im_cs   = 1'b0;
        im_rd   = 1'b0;
        dm_cs   = 1'b0;
        dm_rd   = 1'b0;
        dm_wr   = 1'b0;
        D_En    = 1'b0;
        D_sel   = 2'b00;
        T_Sel   = 1'b0;
        ext_sel = 1'b0;
        HILO_ld = 1'b0;
        Y_Sel   = 3'd0;
        FS      = 5'h00;
        halt    = 1'b0;
        case (state_q)
            S_FETCH: begin
                im_cs  = 1'b1;
                im_rd  = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_EXEC_R: FS = funct_fs(fn_q);
            S_WB_R: begin
                FS    = funct_fs(fn_q);
                D_sel = 2'b00;
                Y_Sel = 3'd2;
                D_En  = 1'b1;
            end
            S_EXEC_MD: begin
                FS      = (fn_q == 6'h18) ? FS_MULT : FS_DIV;
                HILO_ld = 1'b1;
            end
            S_WB_HL: begin
                D_sel = 2'b00;
                Y_Sel = (fn_q == 6'h10) ? 3'd0 : 3'd1;
                D_En  = 1'b1;
            end
            S_JR: begin
                pc_sel = 2'b10;
                pc_ld  = 1'b1;
            end
            S_EXEC_I: begin
                T_Sel   = 1'b1;
                ext_sel = (op_q == 6'h0D);
                FS      = (op_q == 6'h0D) ? FS_OR : FS_ADD;
            end
            S_WB_I: begin
                D_sel = 2'b01;
                Y_Sel = 3'd2;
                D_En  = 1'b1;
            end
            S_LW_ADDR, S_SW_ADDR: begin
                FS    = FS_ADD;
                T_Sel = 1'b1;
            end
            S_LW_MEM: begin
                dm_cs = 1'b1;
                dm_rd = 1'b1;
            end
            S_LW_WB: begin
                D_sel = 2'b01;
                Y_Sel = 3'd3;
                D_En  = 1'b1;
            end
            S_SW_MEM: begin
                dm_cs = 1'b1;
                dm_wr = 1'b1;
            end
            S_BR: begin
                FS     = FS_SUB;
                pc_sel = 2'b00;
                pc_ld  = (op_q == 6'h04) ? Z : ~Z;
            end
            S_J: begin
                pc_sel = 2'b01;
                pc_ld  = 1'b1;
            end
            S_JAL: begin
                pc_sel = 2'b01;
                pc_ld  = 1'b1;
                D_sel  = 2'b10;
                Y_Sel  = 3'd4;
                D_En   = 1'b1;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

endmodule
